// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the nibble-serial adder
//               controller: FSM state encoding, nibble width and a helper
//               that derives the nibble count from the operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibbles needed to cover an operand of the given width
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl_if
// Description : Operand/result handshake bundle for nibble_serial_add_ctrl.
//               master = producer/consumer side, slave = controller side.
//               The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output en, in_valid, a, b,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  en, in_valid, a, b,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_add4_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder / add4_cell
// Description : One-bit full-adder cell and a purely combinational 4-bit
//               ripple-carry adder chained from four of them.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add4_cell
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

  assign co = w_c[NIBBLE_W];
endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : WIDTH-bit adder that reuses one 4-bit ripple cell, one nibble
//               per cycle, LS nibble first, with valid/ready handshakes on
//               the operand and result sides. Optional subtract mode is
//               enabled by defining SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int                 c_nib      = nib_count(WIDTH);
  localparam int                 c_idx_w    = $clog2(c_nib);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nib - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_cout;
  logic                 r_carry;
  logic [c_idx_w-1:0]   r_idx;
`ifdef SERIAL_ADD_SUB_EN
  logic                 r_sub;
`endif

  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;
  logic [NIBBLE_W-1:0]  w_a_nib;
  logic [NIBBLE_W-1:0]  w_b_raw;
  logic [NIBBLE_W-1:0]  w_b_nib;
  logic [NIBBLE_W-1:0]  w_cell_s;
  logic                 w_cell_co;

  // Current nibble of each latched operand, selected by the nibble index
  assign w_a_nib = NIBBLE_W'(r_a >> (r_idx * NIBBLE_W));
  assign w_b_raw = NIBBLE_W'(r_b >> (r_idx * NIBBLE_W));
  assign w_last  = (r_idx == c_last_idx);

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1; the +1 enters as the initial carry
  assign w_b_nib = w_b_raw ^ {NIBBLE_W{r_sub}};
`else
  assign w_b_nib = w_b_raw;
`endif

  add4_cell u_cell (
    .a   (w_a_nib),
    .b   (w_b_nib),
    .cin (r_carry),
    .s   (w_cell_s),
    .co  (w_cell_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived handshake outputs (no input-to-output paths)
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (bus.en) begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-nibble result write-back, carry chain and index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_sum <= '0;
      r_idx <= '0;
`ifdef SERIAL_ADD_SUB_EN
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
`else
      r_carry <= 1'b0;
`endif
    end else if (w_step) begin
      for (int i = 0; i < c_nib; i++) begin
        if (r_idx == c_idx_w'(i)) r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_cell_s;
      end
      r_carry <= w_cell_co;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_cout <= w_cell_co;
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl: directed
//               vector table, stall / back-pressure / mid-run reset
//               sequences, and random operations against an arithmetic
//               reference model. Subtract vectors need SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           s;
    int           stall_after;
    int           stall_len;
    int           hold;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                              input int sa, input int sl, input int h,
                              input logic [W-1:0] sum, input logic cout);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.stall_after = sa; v.stall_len = sl; v.hold = h;
    v.sum = sum; v.cout = cout;
    return v;
  endfunction

  // Reference: full-precision arithmetic, carry-out is bit W of the result
  function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_sub(input bit s);
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: subtract requested without subtract support");
`endif
  endtask

  // One complete operation: accept, RUN with optional en stall, DONE with optional back-pressure
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int stall_after, input int stall_len, input int hold,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat, steps, stalled;
    check({tag, ":in_ready_before"}, bus.in_ready, 1);
    bus.a         = a;
    bus.b         = b;
    set_sub(s);
    bus.in_valid  = 1'b1;
    bus.en        = 1'b1;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ":busy_after_accept"}, bus.busy, 1);
    check({tag, ":in_ready_after_accept"}, bus.in_ready, 0);
    check({tag, ":sum_cleared"}, bus.sum, 0);
    lat = 0; steps = 0; stalled = 0;
    while (!bus.out_valid && lat < 64) begin
      check({tag, ":busy_run"}, bus.busy, 1);
      bus.en = !(steps == stall_after && stalled < stall_len);
      @(negedge clk);
      lat++;
      if (bus.en) steps++;
      else        stalled++;
    end
    bus.en = 1'b1;
    check({tag, ":latency"}, lat, NIB + stall_len);
    check({tag, ":out_valid"}, bus.out_valid, 1);
    check({tag, ":busy_done"}, bus.busy, 0);
    check({tag, ":sum"}, bus.sum, exp_sum);
    check({tag, ":cout"}, bus.cout, exp_cout);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = ~a;
      bus.b        = a;
      bus.en       = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, ":hold_out_valid"}, bus.out_valid, 1);
      check({tag, ":hold_in_ready"}, bus.in_ready, 0);
      check({tag, ":hold_sum"}, bus.sum, exp_sum);
      check({tag, ":hold_cout"}, bus.cout, exp_cout);
    end
    bus.in_valid  = 1'b0;
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, ":out_valid_dropped"}, bus.out_valid, 0);
    check({tag, ":in_ready_after"}, bus.in_ready, 1);
    check({tag, ":busy_after"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    bit           rs;
    logic [W:0]   m;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.en        = 1'b0;
    bus.out_ready = 1'b0;
    set_sub(1'b0);

    vecs.push_back(mk(16'h1234, 16'h0FCD, 1'b0, 0, 0, 0, 16'h2201, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 0, 0, 0, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h00FF, 16'h0001, 1'b0, 2, 3, 0, 16'h0100, 1'b0));
    vecs.push_back(mk(16'h8001, 16'h7FFF, 1'b0, 0, 0, 5, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h0000, 16'h0000, 1'b0, 0, 1, 1, 16'h0000, 1'b0));
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back(mk(16'h0005, 16'h0007, 1'b1, 0, 0, 0, 16'hFFFE, 1'b0));
    vecs.push_back(mk(16'h0007, 16'h0005, 1'b1, 1, 2, 2, 16'h0002, 1'b1));
`endif

    repeat (3) @(negedge clk);
    check("reset:out_valid", bus.out_valid, 0);
    check("reset:busy", bus.busy, 0);
    check("reset:sum", bus.sum, 0);
    check("reset:cout", bus.cout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset:in_ready", bus.in_ready, 1);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].stall_after, vecs[i].stall_len, vecs[i].hold,
             vecs[i].sum, vecs[i].cout);
    end

    // Mid-run reset: leave cout=1 from the previous op, start a new one, reset after one step
    run_op("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 0, 0, 0, 16'h0000, 1'b1);
    bus.a = 16'h1111; bus.b = 16'h2222; set_sub(1'b0);
    bus.in_valid = 1'b1; bus.en = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst:partial_sum", bus.sum, 16'h0003);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst:out_valid", bus.out_valid, 0);
    check("mid_rst:busy", bus.busy, 0);
    check("mid_rst:sum", bus.sum, 0);
    check("mid_rst:cout", bus.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst:in_ready", bus.in_ready, 1);
      check("post_rst:no_out_valid", bus.out_valid, 0);
      check("post_rst:busy", bus.busy, 0);
    end
    run_op("post_rst_op", 16'h0001, 16'h0001, 1'b0, 0, 0, 0, 16'h0002, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'h0000 : W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      m = ref_model(ra, rb, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rs,
             int'($urandom_range(0, NIB - 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), m[W-1:0], m[W]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple-carry adder cell one nibble per cycle, least-significant nibble first. The carry is held in a register between nibbles. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the multi-word extension of the team's registered 4-bit adder and reuses the same full-adder cell.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 8.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  progress enable for RUN state; freezes nibble sequencing when low.
- in_valid  in  1  operand request.
- in_ready  out  1  high iff state == IDLE.
- a  in  WIDTH  operand A; sampled on input handshake.
- b  in  WIDTH  operand B; sampled on input handshake.
- sub  in  1  subtract select (present only with SERIAL_ADD_SUB_EN).
- out_valid  out  1  high iff state == DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result.
- cout  out  1  registered final carry out of the MSB nibble.
- busy  out  1  high iff state == RUN.

## Operation
- NIB = WIDTH/4 nibbles; nibble index register idx is $clog2(NIB) bits wide.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - on in_valid && in_ready: latch a and b; clear sum; idx ← 0; carry ← 0 (carry ← sub with the macro); → RUN.
  - in_valid is ignored in all other states.
- RUN, en=1:
  - adder cell computes a[4*idx+:4] + b'[4*idx+:4] + carry, where b' = b, or ~b when sub=1 with the macro.
  - sum[4*idx+:4] ← cell sum; carry ← cell carry; idx ← idx+1.
  - when idx == NIB-1: cout ← cell carry; → DONE.
- RUN, en=0: all registers hold. en has no effect in IDLE or DONE.
- DONE:
  - sum and cout are stable while out_valid is high.
  - on out_ready: → IDLE.
  - out_ready with out_valid low has no effect.
- Arithmetic is modulo 2^WIDTH. cout is the true carry; in subtract mode cout=1 means no borrow (a ≥ b unsigned).
- Reset, asserted at any time including mid-RUN:
  - state → IDLE; sum, cout, carry, idx, latched operands → 0.
  - out_valid=0 and busy=0; in_ready=1 once reset is released.
  - partial results are discarded; no result is emitted.

## Timing
- Input handshake at edge T0 → busy high during cycles T0+1 … T0+NIB.
- out_valid rises after edge T0+NIB, assuming en held high. For WIDTH=16 this is 4 cycles after the accepting edge.
- Each cycle with en=0 during RUN adds one cycle of latency.
- Best-case throughput: one operation per NIB+2 cycles (accept, NIB RUN cycles, DONE; IDLE re-entered after out handshake).
- There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - sub port exists; sub is latched with the operands.
  - subtract uses b inverted per nibble, with the initial carry equal to sub.
- SERIAL_ADD_SUB_EN undefined:
  - no sub port; add only; initial carry 0; no inverter logic.

## Structure
- Package serial_add_pkg: state enum (IDLE/RUN/DONE), NIBBLE_W = 4 constant, and a function returning NIB from WIDTH.
- Sub-module add4_cell: purely combinational 4-bit ripple adder built from the existing full-adder cell. Ports a[3:0], b[3:0], cin → s[3:0], co.
- The controller holds the FSM, idx, carry, and the operand/result registers, and instantiates one add4_cell.

## Test plan
- WIDTH=16, a=0x1234, b=0x0FCD, en=1, out_ready=1 → sum=0x2201, cout=0; out_valid 4 cycles after accept, high for one cycle.
- a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, which checks carry propagation across all nibbles.
- With SERIAL_ADD_SUB_EN, sub=1:
  - a=0x0005, b=0x0007 → sum=0xFFFE, cout=0.
  - a=0x0007, b=0x0005 → sum=0x0002, cout=1.
- a=0x00FF, b=0x0001 with en low for 3 cycles after the 2nd RUN cycle → sum=0x0100, cout=0; out_valid arrives 3 cycles late; busy stays high throughout the stall.
- out_ready held low 5 cycles in DONE → sum and cout stable, in_ready=0, and a new in_valid is ignored. After out_ready, IDLE is entered and the next operand is accepted.
- rst_n pulsed low mid-RUN → all outputs 0 immediately. After release, in_ready=1 and no stale out_valid appears; the next operation 0x0001+0x0001 gives 0x0002.
